// File: rtl/soundweb_pkg.sv
// Shared constants, FSM state type and byte helpers for the Soundweb
// transmit path. The optional ACK wait feature is enabled by the macro
// SOUNDWEB_ACK_WAIT_EN (the state list always carries S_WAIT_ACK).
package soundweb_pkg;

   localparam logic [7:0] STX        = 8'h02;
   localparam logic [7:0] ETX        = 8'h03;
   localparam logic [7:0] ACK        = 8'h06;
   localparam logic [7:0] NAK        = 8'h15;
   localparam logic [7:0] ESC        = 8'h1B;
   localparam logic [7:0] ESC_OFFSET = 8'h80;
   localparam int         MSG_BYTES  = 13;
   localparam int         MSG_BITS   = 8 * MSG_BYTES;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_STX      = 3'd1,
      S_BODY     = 3'd2,
      S_ESC2     = 3'd3,
      S_CHK      = 3'd4,
      S_ETX      = 3'd5,
      S_WAIT_ACK = 3'd6
   } tx_state_e;

   // Bytes that collide with link control characters and must be escaped.
   function automatic logic is_reserved_byte(input logic [7:0] b);
      case (b)
         8'h02, 8'h03, 8'h06, 8'h15, 8'h1B: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   // Body byte idx (0 = command) of a message; byte 0 lives in the MSBs.
   function automatic logic [7:0] msg_byte(input logic [MSG_BITS-1:0] msg,
                                           input logic [3:0] idx);
      logic [MSG_BITS-1:0] sh;
      sh = msg >> (8 * (MSG_BYTES - 1 - int'(idx)));
      return sh[7:0];
   endfunction

   // XOR of all unescaped body bytes.
   function automatic logic [7:0] msg_checksum(input logic [MSG_BITS-1:0] msg);
      logic [7:0] c;
      c = 8'h00;
      for (int i = 0; i < MSG_BYTES; i++) begin
         c = c ^ msg[8*i +: 8];
      end
      return c;
   endfunction

   // First byte put on the wire for a payload byte: ESC if it needs escaping.
   function automatic logic [7:0] escape_head(input logic [7:0] b);
      return is_reserved_byte(b) ? ESC : b;
   endfunction

endpackage

// File: rtl/soundweb_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid requester at or
// after the pointer, wrapping modulo NUM_REQ. The pointer register is owned
// by the parent.
module soundweb_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_valid_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   grant_idx_o,
   output logic               grant_any_o
);

   // Scan requesters starting from the pointer, keep the first hit.
   always_comb begin
      int         k;
      logic       hit;
      logic [IDX_W-1:0] k_s;
      grant_o     = '0;
      grant_idx_o = '0;
      grant_any_o = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
         k   = int'(ptr_i) + off;
         k   = (k >= NUM_REQ) ? (k - NUM_REQ) : k;
         k_s = IDX_W'(k);
         hit = req_valid_i[k_s] && !grant_any_o;
         grant_o[k_s] = grant_o[k_s] | hit;
         grant_idx_o  = hit ? k_s : grant_idx_o;
         grant_any_o  = grant_any_o | hit;
      end
   end

endmodule

// File: rtl/soundweb_tx_scheduler.sv
// Soundweb transmit scheduler: round-robin grant of 13-byte messages and
// streaming of STX / escaped body / escaped checksum / ETX to a UART.
// Optional macro SOUNDWEB_ACK_WAIT_EN adds an ACK/NAK wait with retries.
module soundweb_tx_scheduler
   import soundweb_pkg::*;
#(
   parameter int          NUM_REQ     = 2,
   parameter logic [15:0] ACK_TIMEOUT = 16'd50000,
   parameter int          MAX_RETRY   = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*104-1:0]  req_msg,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    frame_error
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   tx_state_e            state_q;
   logic [IDX_W-1:0]     ptr_q;
   logic [MSG_BITS-1:0]  msg_q;
   logic [7:0]           chk_q;
   logic [3:0]           idx_q;
   logic                 esc_chk_q;
   logic [7:0]           tx_data_q;
   logic                 tx_valid_q;
   logic                 busy_q;
   logic                 frame_done_q;
   logic                 frame_error_q;

   logic [NUM_REQ-1:0]   grant_s;
   logic [IDX_W-1:0]     grant_idx_s;
   logic                 grant_any_s;
   logic [IDX_W-1:0]     ptr_next_s;
   logic [MSG_BITS-1:0]  grant_msg_s;
   logic [7:0]           cur_byte_s;
   logic [7:0]           next_byte_s;
   logic                 accept_s;

`ifdef SOUNDWEB_ACK_WAIT_EN
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [15:0]          ack_cnt_q;
   logic [RTY_W-1:0]     retry_q;
`else
   logic                 unused_ack_s;
   assign unused_ack_s = ^{rx_data, rx_valid, ACK_TIMEOUT, MAX_RETRY};
`endif

   soundweb_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req_valid_i (req_valid),
      .ptr_i       (ptr_q),
      .grant_o     (grant_s),
      .grant_idx_o (grant_idx_s),
      .grant_any_o (grant_any_s)
   );

   assign ptr_next_s  = (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + IDX_W'(1);
   assign grant_msg_s = req_msg[MSG_BITS*grant_idx_s +: MSG_BITS];
   assign cur_byte_s  = msg_byte(msg_q, idx_q);
   assign next_byte_s = msg_byte(msg_q, idx_q + 4'd1);
   assign accept_s    = tx_valid_q & tx_ready;

   // The accept pulse is only meaningful while idle and out of reset.
   assign req_ready   = {NUM_REQ{rst_n && (state_q == S_IDLE)}} & grant_s;
   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign busy        = busy_q;
   assign frame_done  = frame_done_q;
   assign frame_error = frame_error_q;

   // Frame FSM: tx_data is loaded with the next wire byte on each accept so it
   // holds stable while the UART stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         msg_q         <= '0;
         chk_q         <= 8'h00;
         idx_q         <= 4'd0;
         esc_chk_q     <= 1'b0;
         tx_data_q     <= 8'h00;
         tx_valid_q    <= 1'b0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_error_q <= 1'b0;
`ifdef SOUNDWEB_ACK_WAIT_EN
         ack_cnt_q     <= 16'd0;
         retry_q       <= '0;
`endif
      end else begin
         frame_done_q  <= 1'b0;
         frame_error_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (grant_any_s) begin
                  msg_q      <= grant_msg_s;
                  chk_q      <= msg_checksum(grant_msg_s);
                  ptr_q      <= ptr_next_s;
                  idx_q      <= 4'd0;
                  esc_chk_q  <= 1'b0;
                  tx_data_q  <= STX;
                  tx_valid_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= S_STX;
               end
            end
            S_STX: begin
               if (accept_s) begin
                  idx_q     <= 4'd0;
                  tx_data_q <= escape_head(msg_byte(msg_q, 4'd0));
                  state_q   <= S_BODY;
               end
            end
            S_BODY: begin
               if (accept_s) begin
                  if (is_reserved_byte(cur_byte_s)) begin
                     tx_data_q <= cur_byte_s + ESC_OFFSET;
                     state_q   <= S_ESC2;
                  end else if (idx_q == 4'(MSG_BYTES - 1)) begin
                     tx_data_q <= escape_head(chk_q);
                     state_q   <= S_CHK;
                  end else begin
                     idx_q     <= idx_q + 4'd1;
                     tx_data_q <= escape_head(next_byte_s);
                  end
               end
            end
            S_ESC2: begin
               if (accept_s) begin
                  if (esc_chk_q) begin
                     tx_data_q <= ETX;
                     state_q   <= S_ETX;
                  end else if (idx_q == 4'(MSG_BYTES - 1)) begin
                     tx_data_q <= escape_head(chk_q);
                     state_q   <= S_CHK;
                  end else begin
                     idx_q     <= idx_q + 4'd1;
                     tx_data_q <= escape_head(next_byte_s);
                     state_q   <= S_BODY;
                  end
               end
            end
            S_CHK: begin
               if (accept_s) begin
                  if (is_reserved_byte(chk_q)) begin
                     esc_chk_q <= 1'b1;
                     tx_data_q <= chk_q + ESC_OFFSET;
                     state_q   <= S_ESC2;
                  end else begin
                     tx_data_q <= ETX;
                     state_q   <= S_ETX;
                  end
               end
            end
            S_ETX: begin
               if (accept_s) begin
                  tx_valid_q <= 1'b0;
                  tx_data_q  <= 8'h00;
`ifdef SOUNDWEB_ACK_WAIT_EN
                  ack_cnt_q  <= 16'd0;
                  state_q    <= S_WAIT_ACK;
`else
                  busy_q       <= 1'b0;
                  frame_done_q <= 1'b1;
                  state_q      <= S_IDLE;
`endif
               end
            end
`ifdef SOUNDWEB_ACK_WAIT_EN
            S_WAIT_ACK: begin
               ack_cnt_q <= ack_cnt_q + 16'd1;
               if (rx_valid && (rx_data == ACK)) begin
                  frame_done_q <= 1'b1;
                  retry_q      <= '0;
                  busy_q       <= 1'b0;
                  state_q      <= S_IDLE;
               end else if ((rx_valid && (rx_data == NAK)) ||
                            (ack_cnt_q == ACK_TIMEOUT - 16'd1)) begin
                  if (int'(retry_q) < MAX_RETRY) begin
                     retry_q    <= retry_q + RTY_W'(1);
                     idx_q      <= 4'd0;
                     esc_chk_q  <= 1'b0;
                     tx_data_q  <= STX;
                     tx_valid_q <= 1'b1;
                     state_q    <= S_STX;
                  end else begin
                     frame_error_q <= 1'b1;
                     retry_q       <= '0;
                     busy_q        <= 1'b0;
                     state_q       <= S_IDLE;
                  end
               end
            end
`endif
            default: begin
               tx_valid_q <= 1'b0;
               tx_data_q  <= 8'h00;
               busy_q     <= 1'b0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_soundweb_tx_scheduler.sv
// Scoreboard bench for soundweb_tx_scheduler (default build, NUM_REQ=2).
// Stimulus pushes expected grants and wire bytes; a negedge monitor pops and
// compares every accepted byte, grant pulse and frame_done pulse.
module tb_soundweb_tx_scheduler;

   localparam int N = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N-1:0]     req_valid = '0;
   logic [N*104-1:0] req_msg = '0;
   logic [N-1:0]     req_ready;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready = 1'b1;
   logic [7:0]       rx_data = 8'h00;
   logic             rx_valid = 1'b0;
   logic             busy;
   logic             frame_done;
   logic             frame_error;

   always #5 clk = ~clk;

   soundweb_tx_scheduler #(.NUM_REQ(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_msg     (req_msg),
      .req_ready   (req_ready),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_error (frame_error)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_byte_q[$];
   int         exp_grant_q[$];
   int         model_ptr = 0;
   int         acc_count = 0;
   int         done_count = 0;
   int         frames_expected = 0;
   int         ready_mode = 0;
   bit         stall_done = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic bit reserved(input logic [7:0] b);
      return (b == 8'h02) || (b == 8'h03) || (b == 8'h06) || (b == 8'h15) || (b == 8'h1B);
   endfunction

   task automatic push_esc(input logic [7:0] b);
      if (reserved(b)) begin
         exp_byte_q.push_back(8'h1B);
         exp_byte_q.push_back(b + 8'h80);
      end else begin
         exp_byte_q.push_back(b);
      end
   endtask

   // Reference framing: STX, escaped bytes, escaped XOR, ETX.
   task automatic push_frame(input logic [103:0] m, input int g);
      logic [7:0] c;
      logic [7:0] b;
      c = 8'h00;
      exp_grant_q.push_back(g);
      exp_byte_q.push_back(8'h02);
      for (int i = 0; i < 13; i++) begin
         b = m[8*(12-i) +: 8];
         c = c ^ b;
         push_esc(b);
      end
      push_esc(c);
      exp_byte_q.push_back(8'h03);
      frames_expected++;
   endtask

   function automatic int model_grant(input logic [N-1:0] mask);
      int k;
      for (int off = 0; off < N; off++) begin
         k = (model_ptr + off) % N;
         if (mask[k]) begin
            model_ptr = (k + 1) % N;
            return k;
         end
      end
      return -1;
   endfunction

   function automatic logic [7:0] rand_byte();
      case ($urandom_range(0, 7))
         0: return 8'h02;
         1: return 8'h03;
         2: return 8'h06;
         3: return 8'h15;
         4: return 8'h1B;
         default: return 8'($urandom);
      endcase
   endfunction

   function automatic logic [103:0] rand_msg();
      logic [103:0] m;
      for (int i = 0; i < 13; i++) m[8*i +: 8] = rand_byte();
      return m;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant();
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (req_ready != '0) break;
         n++;
         if (n > 2000) begin
            fail("grant_timeout");
            break;
         end
      end
      step();
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (!busy && !tx_valid && exp_byte_q.size() == 0) break;
         n++;
         if (n > 5000) begin
            fail("idle_timeout");
            break;
         end
      end
   endtask

   task automatic run_frame(input logic [N-1:0] mask, input logic [103:0] m0, input logic [103:0] m1);
      int g;
      g = model_grant(mask);
      push_frame((g == 0) ? m0 : m1, g);
      step();
      req_msg   = {m1, m0};
      req_valid = mask;
      wait_grant();
      req_valid = '0;
      wait_idle();
   endtask

   // UART ready driver: always ready, random, or a one-off 3-cycle stall on ESC.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ($urandom_range(0, 99) < 60);
            default: begin
               if (!stall_done && tx_valid && tx_data == 8'h1B) begin
                  tx_ready = 1'b0;
                  repeat (3) @(posedge clk);
                  #1;
                  tx_ready   = 1'b1;
                  stall_done = 1'b1;
               end else begin
                  tx_ready = 1'b1;
               end
            end
         endcase
      end
   end

   // Monitor: compares DUT outputs against the scoreboard queues.
   initial begin
      logic       prev_valid;
      logic       prev_ready;
      logic [7:0] prev_data;
      logic       done_expect;
      int         g;
      logic [7:0] e;
      prev_valid  = 1'b0;
      prev_ready  = 1'b0;
      prev_data   = 8'h00;
      done_expect = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_valid  = 1'b0;
            prev_ready  = 1'b0;
            done_expect = 1'b0;
         end else begin
            if (frame_done || done_expect) check("frame_done", {31'd0, frame_done}, {31'd0, done_expect});
            if (frame_done) done_count++;
            if (frame_error) fail("frame_error_pulse");
            if (prev_valid && !prev_ready) begin
               check("hold_valid", {31'd0, tx_valid}, 32'd1);
               check("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
            end else if (prev_valid && prev_data == 8'h03) begin
               check("gap_after_etx", {31'd0, tx_valid}, 32'd0);
               check("idle_after_etx", {31'd0, busy}, 32'd0);
            end else if (prev_valid) begin
               check("continuous_valid", {31'd0, tx_valid}, 32'd1);
            end
            if (tx_valid) check("busy_in_frame", {31'd0, busy}, 32'd1);
            if (req_ready != '0) begin
               if (exp_grant_q.size() == 0) begin
                  fail("unexpected_grant");
               end else begin
                  g = exp_grant_q.pop_front();
                  check("grant", 32'(req_ready), 32'd1 << g);
                  check("grant_in_idle", {31'd0, busy}, 32'd0);
               end
            end
            done_expect = 1'b0;
            if (tx_valid && tx_ready) begin
               acc_count++;
               if (exp_byte_q.size() == 0) begin
                  fail("unexpected_byte");
               end else begin
                  e = exp_byte_q.pop_front();
                  check("byte", {24'd0, tx_data}, {24'd0, e});
                  if (e == 8'h03) done_expect = 1'b1;
               end
            end
            prev_valid = tx_valid;
            prev_ready = tx_ready;
            prev_data  = tx_data;
         end
      end
   end

   // Stimulus.
   initial begin
      logic [103:0] msg1;
      logic [103:0] msg2;
      logic [103:0] ma;
      logic [103:0] mb;
      int           base;
      int           n;
      int           g;
      msg1 = 104'h88_00_01_03_00_01_00_00_00_00_00_00_05;
      msg2 = 104'h8C_00_00_00_00_00_00_00_00_00_00_00_8E;

      #12;
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_frame_error", {31'd0, frame_error}, 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // Reference frame and checksum-escape frame at full rate.
      run_frame(2'b01, msg1, 104'd0);
      run_frame(2'b01, msg2, 104'd0);

      // Backpressure on the first ESC byte.
      ready_mode = 2;
      run_frame(2'b01, msg1, 104'd0);
      ready_mode = 0;
      check("stall_happened", {31'd0, stall_done}, 32'd1);

      // Align pointer to 0, then hold both requesters for three frames.
      run_frame(2'b10, 104'd0, msg2);
      ma = rand_msg();
      mb = rand_msg();
      for (int i = 0; i < 3; i++) begin
         g = model_grant(2'b11);
         push_frame((g == 0) ? ma : mb, g);
      end
      step();
      req_msg   = {mb, ma};
      req_valid = 2'b11;
      for (int i = 0; i < 3; i++) wait_grant();
      req_valid = '0;
      wait_idle();

      // Asynchronous reset in the middle of the body.
      step();
      g = model_grant(2'b01);
      push_frame(msg1, g);
      req_msg   = {104'd0, msg1};
      req_valid = 2'b01;
      base = acc_count;
      n = 0;
      while (acc_count < base + 6 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) fail("reset_setup_timeout");
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      exp_byte_q.delete();
      exp_grant_q.delete();
      frames_expected--;
      model_ptr = 0;
      g = model_grant(2'b01);
      push_frame(msg1, g);
      step();
      rst_n = 1'b1;
      wait_grant();
      req_valid = '0;
      wait_idle();

      // Randomised frames with random backpressure.
      ready_mode = 1;
      for (int i = 0; i < 40; i++) begin
         run_frame(2'($urandom_range(1, 3)), rand_msg(), rand_msg());
      end
      ready_mode = 0;
      step();
      step();

      check("frame_done_count", 32'(done_count), 32'(frames_expected));
      check("bytes_left", 32'(exp_byte_q.size()), 32'd0);
      check("grants_left", 32'(exp_grant_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
